axi_read_intf: RTL and testbench

//  AXI4 read-slave front end: accepts AR bursts, issues one single-beat read per beat to the

---
 rtl/axi_read_intf.sv | 199 +++++++++++++++++++
 tb/tb_axi_read_intf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_intf.sv
// axi_read_intf: AXI4 read-slave front end.
// Accepts one AR burst at a time, issues one single-beat read per beat to the
// internal memory side and returns each beat on the R channel. At most one
// beat is outstanding on the memory side.
// Optional feature macro: AXI_RD_WRAP_EN enables WRAP burst addressing;
// without it a WRAP burst is answered with SLVERR on every beat.
module axi_read_intf #(
   parameter int ARID_WIDTH   = 8,
   parameter int ARADDR_WIDTH = 11,
   parameter int RDATA_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ARID_WIDTH-1:0]   ARID,
   input  logic [ARADDR_WIDTH-1:0] ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic [3:0]              ARREGION,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ARID_WIDTH-1:0]   RID,
   output logic [RDATA_WIDTH-1:0]  RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic                    axi_rd_req,
   output logic [ARADDR_WIDTH-1:0] axi_rd_addr,
   output logic [1:0]              axi_rd_region,
   input  logic [RDATA_WIDTH-1:0]  axi_rd_data,
   input  logic                    axi_rd_data_vld,
   input  logic                    axi_rd_err
);

   localparam int         MAX_SIZE = $clog2(RDATA_WIDTH / 8);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SEND} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [ARID_WIDTH-1:0]   r_id;
   logic [ARADDR_WIDTH-1:0] r_addr;
   logic [2:0]              r_size;
   logic [1:0]              r_burst;
   logic [1:0]              r_region;
   logic [7:0]              r_cnt;
   logic                    r_cfg_err;
   logic [RDATA_WIDTH-1:0]  r_rdata;
   logic [1:0]              r_rresp;
   logic                    r_rlast;
   logic                    w_ar_cfg_err;
   logic [ARADDR_WIDTH-1:0] w_step;
   logic [ARADDR_WIDTH-1:0] w_incr;
   logic [ARADDR_WIDTH-1:0] w_next_addr;
   logic                    w_unused_region;

`ifdef AXI_RD_WRAP_EN
   logic [7:0]              r_len;
   logic [ARADDR_WIDTH-1:0] w_mask;
   logic                    w_wrap_len_ok;
`endif

   // Only the low two region bits travel to the memory side.
   assign w_unused_region = ^ARREGION[3:2];

   // Burst configuration check, evaluated on the incoming AR request.
   always_comb begin
`ifdef AXI_RD_WRAP_EN
      w_wrap_len_ok = (ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15);
      w_ar_cfg_err  = (ARSIZE > 3'(MAX_SIZE)) || (ARBURST == BURST_RSVD) ||
                      ((ARBURST == BURST_WRAP) && !w_wrap_len_ok);
`else
      w_ar_cfg_err  = (ARSIZE > 3'(MAX_SIZE)) || (ARBURST == BURST_RSVD) ||
                      (ARBURST == BURST_WRAP);
`endif
   end

   // Address of the following beat; reserved bursts advance like INCR.
   always_comb begin
      w_step = ARADDR_WIDTH'(1) << r_size;
      w_incr = r_addr + w_step;
`ifdef AXI_RD_WRAP_EN
      w_mask = (ARADDR_WIDTH'({1'b0, r_len} + 9'd1) << r_size) - ARADDR_WIDTH'(1);
`endif
      case (r_burst)
         BURST_FIXED: w_next_addr = r_addr;
`ifdef AXI_RD_WRAP_EN
         BURST_WRAP:  w_next_addr = (r_addr & ~w_mask) | (w_incr & w_mask);
`endif
         default:     w_next_addr = w_incr;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_state_next = r_state;
      ARREADY      = 1'b0;
      RVALID       = 1'b0;
      axi_rd_req   = 1'b0;
      case (r_state)
         S_IDLE: begin
            ARREADY = 1'b1;
            if (ARVALID) w_state_next = S_REQ;
         end
         S_REQ: begin
            axi_rd_req   = !r_cfg_err;
            w_state_next = r_cfg_err ? S_SEND : S_WAIT;
         end
         S_WAIT: begin
            if (axi_rd_data_vld) w_state_next = S_SEND;
         end
         S_SEND: begin
            RVALID = 1'b1;
            if (RREADY) w_state_next = r_rlast ? S_IDLE : S_REQ;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Burst context capture, beat data capture and address/count advance.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: these are plain registers, not a memory array, so all of them take the reset.
      if (rst) begin
         r_id      <= '0;
         r_addr    <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_region  <= '0;
         r_cnt     <= '0;
         r_cfg_err <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rlast   <= 1'b0;
`ifdef AXI_RD_WRAP_EN
         r_len     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ARVALID) begin
                  r_id      <= ARID;
                  r_addr    <= ARADDR;
                  r_size    <= ARSIZE;
                  r_burst   <= ARBURST;
                  r_region  <= ARREGION[1:0];
                  r_cnt     <= ARLEN;
                  r_cfg_err <= w_ar_cfg_err;
`ifdef AXI_RD_WRAP_EN
                  r_len     <= ARLEN;
`endif
               end
            end
            S_REQ: begin
               if (r_cfg_err) begin
                  r_rdata <= '0;
                  r_rresp <= RESP_SLVERR;
                  r_rlast <= (r_cnt == 8'd0);
               end
            end
            S_WAIT: begin
               if (axi_rd_data_vld) begin
                  r_rdata <= axi_rd_data;
                  r_rresp <= axi_rd_err ? RESP_SLVERR : RESP_OKAY;
                  r_rlast <= (r_cnt == 8'd0);
               end
            end
            S_SEND: begin
               if (RREADY && !r_rlast) begin
                  r_cnt  <= r_cnt - 8'd1;
                  r_addr <= w_next_addr;
               end
            end
            default: ;
         endcase
      end
   end

   assign RID           = r_id;
   assign RDATA         = r_rdata;
   assign RRESP         = r_rresp;
   assign RLAST         = r_rlast;
   assign axi_rd_addr   = r_addr;
   assign axi_rd_region = r_region;

endmodule

// File: tb/tb_axi_read_intf.sv
// tb_axi_read_intf: directed and randomized bursts against a burst-level
// reference model (address list and response per beat computed from the
// burst parameters). Inputs change and outputs are sampled on the falling edge.
module tb_axi_read_intf;

   localparam int IW = 8;
   localparam int AW = 11;
   localparam int DW = 32;
`ifdef AXI_RD_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] ARID;
   logic [AW-1:0] ARADDR;
   logic [7:0]    ARLEN;
   logic [2:0]    ARSIZE;
   logic [1:0]    ARBURST;
   logic [3:0]    ARREGION;
   logic          ARVALID;
   logic          ARREADY;
   logic [IW-1:0] RID;
   logic [DW-1:0] RDATA;
   logic [1:0]    RRESP;
   logic          RLAST;
   logic          RVALID;
   logic          RREADY;
   logic          axi_rd_req;
   logic [AW-1:0] axi_rd_addr;
   logic [1:0]    axi_rd_region;
   logic [DW-1:0] axi_rd_data;
   logic          axi_rd_data_vld;
   logic          axi_rd_err;

   int checks = 0;
   int errors = 0;

   axi_read_intf #(.ARID_WIDTH(IW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
      .RREADY(RREADY),
      .axi_rd_req(axi_rd_req), .axi_rd_addr(axi_rd_addr), .axi_rd_region(axi_rd_region),
      .axi_rd_data(axi_rd_data), .axi_rd_data_vld(axi_rd_data_vld), .axi_rd_err(axi_rd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: error decision and the full address list of a burst.
   task automatic model(input int start, input int len, input int size, input int burst,
                        output bit cfg_err, output int addrs[$]);
      int bytes, block, base;
      bit wrap_ok;
      addrs   = {};
      wrap_ok = WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15);
      cfg_err = (size > 2) || (burst == 3) || (burst == 2 && !wrap_ok);
      bytes   = 1 << size;
      block   = (len + 1) * bytes;
      base    = (start / block) * block;
      for (int i = 0; i <= len; i++) begin
         if (burst == 0)                addrs.push_back(start);
         else if (burst == 2 && wrap_ok) addrs.push_back(base + ((start - base) + i * bytes) % block);
         else                           addrs.push_back((start + i * bytes) % (1 << AW));
      end
   endtask

   task automatic run_burst(input string name, input logic [7:0] id, input int addr,
                            input int len, input int size, input int burst,
                            input logic [3:0] region, input int stall_beat, input int stall_cyc,
                            input int err_beat, input bit rand_err);
      bit            cerr;
      int            ea[$];
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_resp;
      bit            e;
      int            lat, stall;
      model(addr, len, size, burst, cerr, ea);
      @(negedge clk);
      check({name, "_arready_idle"}, ARREADY, 1'b1);
      ARID = id; ARADDR = AW'(addr); ARLEN = 8'(len); ARSIZE = 3'(size);
      ARBURST = 2'(burst); ARREGION = region; ARVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      check({name, "_arready_busy"}, ARREADY, 1'b0);
      for (int b = 0; b <= len; b++) begin
         if (!cerr) begin
            check($sformatf("%s_req%0d", name, b), axi_rd_req, 1'b1);
            check($sformatf("%s_addr%0d", name, b), axi_rd_addr, 64'(ea[b]));
            check($sformatf("%s_region%0d", name, b), axi_rd_region, region[1:0]);
            lat = $urandom_range(1, 4);
            repeat (lat) begin
               @(negedge clk);
               check($sformatf("%s_wait_noreq%0d", name, b), axi_rd_req, 1'b0);
               check($sformatf("%s_wait_norvalid%0d", name, b), RVALID, 1'b0);
            end
            exp_data = $urandom;
            e = (b == err_beat) || (rand_err && $urandom_range(0, 7) == 0);
            exp_resp = e ? 2'b10 : 2'b00;
            axi_rd_data = exp_data; axi_rd_err = e; axi_rd_data_vld = 1'b1;
            @(negedge clk);
            axi_rd_data_vld = 1'b0; axi_rd_err = 1'b0; axi_rd_data = $urandom;
         end else begin
            check($sformatf("%s_noreq%0d", name, b), axi_rd_req, 1'b0);
            @(negedge clk);
            exp_data = '0;
            exp_resp = 2'b10;
         end
         check($sformatf("%s_rvalid%0d", name, b), RVALID, 1'b1);
         check($sformatf("%s_rdata%0d", name, b), RDATA, exp_data);
         check($sformatf("%s_rresp%0d", name, b), RRESP, exp_resp);
         check($sformatf("%s_rlast%0d", name, b), RLAST, (b == len));
         check($sformatf("%s_rid%0d", name, b), RID, id);
         stall = (b == stall_beat) ? stall_cyc : $urandom_range(0, 2);
         repeat (stall) begin
            @(negedge clk);
            check($sformatf("%s_hold_rvalid%0d", name, b), RVALID, 1'b1);
            check($sformatf("%s_hold_rdata%0d", name, b), RDATA, exp_data);
            check($sformatf("%s_hold_rlast%0d", name, b), RLAST, (b == len));
            check($sformatf("%s_hold_noreq%0d", name, b), axi_rd_req, 1'b0);
         end
         RREADY = 1'b1;
         @(negedge clk);
         RREADY = 1'b0;
         check($sformatf("%s_rvalid_drop%0d", name, b), RVALID, 1'b0);
      end
      check({name, "_arready_back"}, ARREADY, 1'b1);
   endtask

   initial begin
      int len, size, burst;
      rst = 1'b1;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARREGION = '0;
      ARVALID = 1'b0; RREADY = 1'b0;
      axi_rd_data = '0; axi_rd_data_vld = 1'b0; axi_rd_err = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_arready", ARREADY, 1'b1);
      check("rst_rvalid", RVALID, 1'b0);
      check("rst_rlast", RLAST, 1'b0);
      check("rst_req", axi_rd_req, 1'b0);
      check("rst_rdata", RDATA, '0);
      check("rst_rid", RID, '0);
      check("rst_rresp", RRESP, '0);
      check("rst_addr", axi_rd_addr, '0);
      check("rst_region", axi_rd_region, '0);
      rst = 1'b0;

      run_burst("incr", 8'h5A, 'h010, 3, 2, 1, 4'h1, 1, 5, -1, 1'b0);
      run_burst("fixed", 8'h11, 'h020, 2, 2, 0, 4'h2, -1, 0, -1, 1'b0);
      run_burst("wrap", 8'h22, 'h018, 3, 2, 2, 4'h3, -1, 0, -1, 1'b0);
      run_burst("wrap8", 8'h23, 'h00A, 7, 1, 2, 4'h6, -1, 0, -1, 1'b0);
      run_burst("wrap_len2", 8'h24, 'h030, 2, 2, 2, 4'h0, -1, 0, -1, 1'b0);
      run_burst("size3", 8'h33, 'h040, 1, 3, 1, 4'h1, -1, 0, -1, 1'b0);
      run_burst("rderr", 8'h44, 'h100, 3, 2, 1, 4'h2, -1, 0, 2, 1'b0);
      run_burst("rsvd", 8'h55, 'h200, 1, 2, 3, 4'h3, -1, 0, -1, 1'b0);
      run_burst("incr_roll", 8'h66, 'h7FC, 2, 2, 1, 4'hD, -1, 0, -1, 1'b0);
      run_burst("single_byte", 8'h67, 'h7FF, 0, 0, 1, 4'hE, -1, 0, -1, 1'b0);

      // Reset while a beat is outstanding on the memory side.
      @(negedge clk);
      ARID = 8'h77; ARADDR = 11'h080; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
      ARREGION = 4'h2; ARVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      check("rstw_req", axi_rd_req, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstw_arready", ARREADY, 1'b1);
      check("rstw_rvalid", RVALID, 1'b0);
      check("rstw_req_low", axi_rd_req, 1'b0);
      check("rstw_rid", RID, '0);
      check("rstw_addr", axi_rd_addr, '0);
      @(negedge clk);
      rst = 1'b0;
      axi_rd_data = 32'hDEAD_BEEF; axi_rd_data_vld = 1'b1;
      @(negedge clk);
      axi_rd_data_vld = 1'b0;
      repeat (3) begin
         check("rstw_late_rvalid", RVALID, 1'b0);
         check("rstw_late_arready", ARREADY, 1'b1);
         check("rstw_late_req", axi_rd_req, 1'b0);
         @(negedge clk);
      end
      run_burst("after_rst", 8'h78, 'h0C0, 3, 2, 1, 4'h1, -1, 0, -1, 1'b0);

      // Randomized bursts.
      for (int n = 0; n < 25; n++) begin
         burst = $urandom_range(0, 3);
         len   = $urandom_range(0, 7);
         if (burst == 2 && $urandom_range(0, 2) != 0) len = (2 << $urandom_range(0, 3)) - 1;
         size  = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
         run_burst($sformatf("rnd%0d", n), 8'($urandom), $urandom_range(0, 2047), len, size,
                   burst, 4'($urandom), $urandom_range(0, 7), $urandom_range(0, 4), -1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
